// File: rtl/gfx_bus_pkg.sv
// Shared register map and types for the graphics register-bus initiator.
// Read support is enabled with GFX_BUS_READ_EN.
package gfx_bus_pkg;

  localparam logic [3:0] REG_MODE    = 4'd0;
  localparam logic [3:0] REG_DATA    = 4'd1;
  localparam logic [3:0] REG_ADDR_LO = 4'd3;
  localparam logic [3:0] REG_ADDR_HI = 4'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] rs;
    logic       we;
    logic [7:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/gfx_req_fifo.sv
// Request FIFO: synchronous, registered full/empty flags.
// Latency 1 clk push-to-visible; full blocks pushes, pop ignored when empty.
// Backpressure: producer must hold push_vld until !full.
module gfx_req_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_bus_master.sv
// Register-bus initiator: FIFOs requests and replays each as one phi2 bus cycle.
// Latency 1..2*CLK_DIV+1 clk accept-to-bus; req_ready drops while the FIFO is full.
// GFX_BUS_READ_EN adds read cycles with data capture; otherwise every request is a write.
module gfx_bus_master
  import gfx_bus_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_rs,
  input  logic       req_we,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       phi2_o,
  output logic       cs_n_o,
  output logic [3:0] rs_o,
  output logic       wren_n_o,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] phase_cnt;
  logic             phi2_q;
  state_t           state_q, state_d;
  req_t             push_dat, head_dat;
  logic             push_vld, fifo_full, fifo_empty;
  logic             launch_slot, capture_slot;
  logic             load_req, drop_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      phi2_q    <= 1'b0;
    end else if (phase_cnt == CNT_MAX) begin
      phase_cnt <= '0;
      phi2_q    <= ~phi2_q;
    end else begin
      phase_cnt <= phase_cnt + CNT_ONE;
    end
  end

  assign phi2_o       = phi2_q;
  assign launch_slot  = !phi2_q && (phase_cnt == '0);
  assign capture_slot = phi2_q && (phase_cnt == CNT_MAX);

  assign req_ready      = !fifo_full;
  assign push_vld       = req_valid && !fifo_full;
  assign push_dat.rs    = req_rs;
  assign push_dat.wdata = req_wdata;
`ifdef GFX_BUS_READ_EN
  assign push_dat.we    = req_we;
`else
  assign push_dat.we    = 1'b1;
`endif

  gfx_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (load_req),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (launch_slot) state_d = fifo_empty ? IDLE : ACTIVE;
  end

  always_comb begin
    load_req = 1'b0;
    drop_bus = 1'b0;
    if (launch_slot) begin
      if (!fifo_empty)            load_req = 1'b1;
      else if (state_q == ACTIVE) drop_bus = 1'b1;
    end
  end

  assign busy = !fifo_empty || (state_q == ACTIVE);

  // Bus pins only move after the launch slot, giving one clk of hold past phi2 fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_o   <= 1'b1;
      rs_o     <= '0;
      wren_n_o <= 1'b1;
      data_o   <= '0;
    end else if (load_req) begin
      cs_n_o   <= 1'b0;
      rs_o     <= head_dat.rs;
      wren_n_o <= ~head_dat.we;
      if (head_dat.we) data_o <= head_dat.wdata;
    end else if (drop_bus) begin
      cs_n_o   <= 1'b1;
      wren_n_o <= 1'b1;
    end
  end

`ifdef GFX_BUS_READ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_oe <= 1'b0;
    end else if (load_req) begin
      data_oe <= head_dat.we;
    end else if (drop_bus) begin
      data_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (capture_slot && !cs_n_o && wren_n_o) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= data_i;
    end else begin
      rsp_valid <= 1'b0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{req_we, data_i, capture_slot};
  assign data_oe   = ~cs_n_o;
  assign rsp_valid = 1'b0;
  assign rsp_rdata = '0;
`endif

endmodule

// File: tb/tb_gfx_bus_master.sv
// Directed bench for gfx_bus_master at CLK_DIV=4, FIFO_DEPTH=4.
// Builds with or without GFX_BUS_READ_EN; read or read-disabled vectors follow the build.
module tb_gfx_bus_master;
  import gfx_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_rs = '0;
  logic       req_we = 1'b0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       phi2_o;
  logic       cs_n_o;
  logic [3:0] rs_o;
  logic       wren_n_o;
  logic [7:0] data_o;
  logic       data_oe;
  logic [7:0] data_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  gfx_bus_master #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .phi2_o    (phi2_o),
    .cs_n_o    (cs_n_o),
    .rs_o      (rs_o),
    .wren_n_o  (wren_n_o),
    .data_o    (data_o),
    .data_oe   (data_oe),
    .data_i    (data_i)
  );

  always #5 clk = ~clk;

  // Clk edges since reset release: phase = cyc%4, phi2 = (cyc/4)%2, launch when cyc%8==0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    data_i = phi2_o ? 8'h3C : 8'h00;
  endtask

  task automatic push_req(input logic [3:0] rs, input logic we, input logic [7:0] wd);
    req_valid = 1'b1;
    req_rs    = rs;
    req_we    = we;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while ((cyc % 8) != 0 && n < 16) begin
      tick();
      n++;
    end
    if (n >= 16) chk({tag, "_launch_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic bus_cycle(input string tag, input logic [3:0] rs, input logic wren_n,
                           input logic [7:0] dat, input logic oe, input logic rd);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, "_bus"}, {cs_n_o, rs_o, wren_n_o, data_o, data_oe}, {1'b0, rs, wren_n, dat, oe});
      chk({tag, "_rspv"}, rsp_valid, rd && (k == 8));
      if (rd && k == 8) chk({tag, "_rdata"}, rsp_rdata, 8'h3C);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] got_rs[$];
    logic [7:0] got_dat[$];
    int idx;
    int lows;
    logic was_rdy;
    logic [3:0] b2b_rs[4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus", {cs_n_o, rs_o, wren_n_o, data_o, data_oe}, {1'b1, 4'h0, 1'b1, 8'h00, 1'b0});
    chk("rst_phi2", phi2_o, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 9'h000);
    rst_n = 1'b1;

    // Phase clock: 4 clk per half period, starting low
    for (int i = 0; i < 16; i++) begin
      chk("phi2", phi2_o, ((cyc / 4) % 2) != 0);
      tick();
    end

    // Single write
    push_req(REG_DATA, 1'b1, 8'hA5);
    chk("wr_busy", busy, 1'b1);
    wait_launch("wr");
    bus_cycle("wr", REG_DATA, 1'b0, 8'hA5, 1'b1, 1'b0);
    tick();
    chk("wr_end", {cs_n_o, wren_n_o, data_oe, busy}, 4'b1100);

`ifdef GFX_BUS_READ_EN
    push_req(REG_ADDR_LO, 1'b0, 8'h00);
    wait_launch("rd");
    bus_cycle("rd", REG_ADDR_LO, 1'b1, 8'hA5, 1'b0, 1'b1);
    tick();
    chk("rd_end", {cs_n_o, rsp_valid, rsp_rdata}, {1'b1, 1'b0, 8'h3C});
`else
    push_req(4'd2, 1'b0, 8'h11);
    wait_launch("rdoff");
    bus_cycle("rdoff", 4'd2, 1'b0, 8'h11, 1'b1, 1'b0);
    tick();
    chk("rdoff_end", {cs_n_o, rsp_valid, rsp_rdata}, {1'b1, 1'b0, 8'h00});
`endif

    // Back-to-back writes fill the FIFO
    while ((cyc % 8) != 1) tick();
    b2b_rs = '{REG_MODE, REG_DATA, REG_ADDR_LO, REG_ADDR_HI};
    for (int i = 0; i < 4; i++) push_req(b2b_rs[i], 1'b1, 8'h10 + 8'(i));
    chk("b2b_full", req_ready, 1'b0);
    wait_launch("b2b");
    for (int i = 0; i < 4; i++) bus_cycle("b2b", b2b_rs[i], 1'b0, 8'h10 + 8'(i), 1'b1, 1'b0);
    tick();
    chk("b2b_end", {cs_n_o, busy, req_ready}, 3'b101);

    // Six writes with req_valid held: order preserved, ready returns after each pop
    idx = 0;
    for (int c = 0; c < 72; c++) begin
      if ((cyc % 8) == 1 && !cs_n_o) begin
        got_rs.push_back(rs_o);
        got_dat.push_back(data_o);
        chk("ff_ready", req_ready, 1'b1);
      end
      was_rdy = 1'b0;
      if (idx < 6) begin
        req_valid = 1'b1;
        req_rs    = 4'(idx + 5);
        req_we    = 1'b1;
        req_wdata = 8'hC0 + 8'(idx);
        was_rdy   = req_ready;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (was_rdy) idx++;
    end
    req_valid = 1'b0;
    chk("ff_count", got_rs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_rs.size()) chk("ff_entry", {got_rs[i], got_dat[i]}, {4'(i + 5), 8'hC0 + 8'(i)});
    end
    chk("ff_idle", {busy, cs_n_o}, 2'b01);

    // Asynchronous reset mid-write drops the bus and pending requests
    push_req(REG_ADDR_HI, 1'b1, 8'h5A);
    push_req(REG_MODE, 1'b1, 8'h66);
    wait_launch("ar");
    repeat (5) tick();
    chk("ar_pre", {cs_n_o, phi2_o, data_oe}, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_bus", {cs_n_o, rs_o, wren_n_o, data_o, data_oe}, {1'b1, 4'h0, 1'b1, 8'h00, 1'b0});
    chk("ar_phi2", phi2_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_flags", {busy, req_ready}, 2'b01);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!cs_n_o) lows++;
    end
    chk("ar_drop", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gfx_bus_master.md
# gfx_bus_master

Host-side initiator for the graphics adapter's 8-bit register bus. Accepts register write/read requests on a valid/ready interface, buffers them in a small FIFO, and replays each one as a single bus cycle on `phi2_o`/`cs_n_o`/`rs_o`/`wren_n_o`/data. It generates the free-running phase clock the adapter uses as its external bus clock. Sits between the test/host logic (or a soft CPU) and the adapter's `cs`/`rs`/`wren`/`data_bi` pins.

## Interface
Parameters:
- `CLK_DIV`, 25: `clk` cycles per phi2 half-period. Minimum 2. The default gives 1 MHz from 50 MHz.
- `FIFO_DEPTH`, 4: request FIFO entries. Power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  FIFO not full.
- `req_rs`  in  4  register index.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-clk pulse; read data valid.
- `rsp_rdata`  out  8  captured read data.
- `busy`  out  1  FIFO non-empty or a bus cycle is in progress.
- `phi2_o`  out  1  bus phase clock, 50% duty, free-running.
- `cs_n_o`  out  1  chip select, active-low.
- `rs_o`  out  4  register select.
- `wren_n_o`  out  1  0 = write cycle, 1 = read cycle.
- `data_o`  out  8  write data to the pad.
- `data_oe`  out  1  pad output enable.
- `data_i`  in  8  data from the pad.

## Operation
- Phase counter `phase_cnt` (width `$clog2(CLK_DIV)`) counts 0 to CLK_DIV-1, then wraps to 0.
  - On the wrap, `phi2_o` toggles.
  - The first clk of each phi2 level has `phase_cnt == 0`.
- **Launch slot:** the clk where `phi2_o == 0 && phase_cnt == 0`. It is the only clk in which bus outputs are updated; new values appear on the following clk.
- **FSM states:**
  - IDLE → ACTIVE at the launch slot if the FIFO is non-empty.
  - ACTIVE → ACTIVE at the next launch slot if the FIFO is non-empty (back-to-back).
  - ACTIVE → IDLE at the next launch slot if the FIFO is empty.
- **Entering ACTIVE:**
  - Pop the FIFO head.
  - Drive `cs_n_o = 0`, `rs_o = req_rs`, `wren_n_o = ~req_we`.
  - For a write: `data_o = req_wdata`, `data_oe = 1`. For a read: `data_oe = 0`.
- **Entering IDLE:** `cs_n_o = 1`, `wren_n_o = 1`, `data_oe = 0`. `rs_o` and `data_o` hold their last values.
- Because outputs only change after the launch slot, every bus value is held one clk past the falling edge of `phi2_o`. The adapter latches `rs` on the rising edge and data on the falling edge of `phi2 & ~cs`.
- **Read capture:** in the clk where `phi2_o == 1 && phase_cnt == CLK_DIV-1` during a read cycle:
  - `rsp_rdata <= data_i`.
  - `rsp_valid` pulses high for 1 clk starting on the next clk.
  - `rsp_rdata` holds until the next capture.
- **FIFO:** `req_ready = !full`. A push happens when `req_valid && req_ready`.
- **FIFO boundaries:**
  - Push and pop in the same clk are both honoured, including when the FIFO is full (`req_ready` is 0 that clk, so no push occurs).
  - Pop when empty cannot occur.
- `busy = !empty || state == ACTIVE`.
- **Reset (asynchronous, including mid-cycle):**
  - `phi2_o = 0`, `phase_cnt = 0`, state IDLE.
  - `cs_n_o = 1`, `rs_o = 0`, `wren_n_o = 1`, `data_o = 0`, `data_oe = 0`.
  - `rsp_valid = 0`, `rsp_rdata = 0`, FIFO emptied (`req_ready = 1`, `busy = 0`).
  - Pending requests are dropped.

## Timing
- One bus cycle per phi2 period (2·CLK_DIV clk). `cs_n_o` stays low across back-to-back cycles.
- Address/data setup before the rising edge of `phi2_o`: CLK_DIV-1 clk.
- Write data valid across the whole falling edge of `phi2_o`, plus 1 clk hold.
- Accept-to-bus latency: between 1 and 2·CLK_DIV+1 clk, depending on the phase at which the request is pushed.
- Read: `rsp_valid` is asserted exactly 2·CLK_DIV clk after the launch-slot clk that starts the cycle.

## Configuration
- `GFX_BUS_READ_EN` defined: full read support as described above.
- Undefined:
  - `req_we` is ignored and every request is a write.
  - `rsp_valid` and `rsp_rdata` are tied to 0.
  - `data_i` is unused.
  - `data_oe` equals `~cs_n_o`.

## Structure
- Package `gfx_bus_pkg` holds:
  - register index constants: `REG_MODE = 4'd0`, `REG_DATA = 4'd1`, `REG_ADDR_LO = 4'd3`, `REG_ADDR_HI = 4'd4`;
  - FSM state typedef (IDLE, ACTIVE);
  - packed request typedef {rs[3:0], we, wdata[7:0]}.
- Sub-module `gfx_req_fifo`: synchronous FIFO of 13-bit request entries with full/empty flags. The phase counter and FSM stay in the top module.

## Test plan
All scenarios use CLK_DIV=4, FIFO_DEPTH=4.
- **Reset check:** assert `rst_n` low mid-write → same clk: `cs_n_o=1`, `data_oe=0`, `phi2_o=0`. After release, `busy=0`, `req_ready=1`.
- **Single write:** push {rs=1, we=1, wdata=8'hA5} → from the first launch slot after the push, `cs_n_o=0`, `rs_o=1`, `wren_n_o=0`, `data_o=A5` for 8 clk. `cs_n_o=1` after the following launch slot.
- **Read:** push {rs=3, we=0}, bench drives `data_i=8'h3C` while `phi2_o=1` → `rsp_valid` pulses once with `rsp_rdata=3C`, 8 clk after launch. `data_oe=0` throughout.
- **Back-to-back writes:** push 4 writes (rs=0,1,3,4) → `req_ready=0` after the 4th push. Four consecutive phi2 periods with `cs_n_o` continuously low and `rs_o` sequence 0,1,3,4. Then `busy` drops.
- **Full FIFO:** hold `req_valid` with 6 writes → exactly 6 bus cycles in order, no loss or duplication. `req_ready` reasserts the clk after each pop.
- **Read disabled:** with `GFX_BUS_READ_EN` undefined, push {we=0, rs=2, wdata=8'h11} → write cycle with `wren_n_o=0`, `data_o=11`, `rsp_valid` never asserted.
